// File: rtl/slc3_io_pkg.sv
// Shared types and constants for the SLC-3 memory-mapped I/O responder:
// FSM state encoding, decoded addresses and the active-low 7-segment table.
package slc3_io_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2,
        HOLD = 2'd3
    } io_state_t;

    localparam logic [15:0] IO_HEX_ADDR = 16'hFFFF;
    localparam logic [15:0] IO_LED_ADDR = 16'hFFFE;

    // Segments are active-low; bit7 is the decimal point and stays off.
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Indexed by nibble value; element 0 is the LSB slice of the packed array.
    localparam logic [15:0][7:0] SEG_TABLE = {
        8'h8E, 8'h86, 8'hA1, 8'hC6,   // F E D C
        8'h83, 8'h88, 8'h90, 8'h80,   // B A 9 8
        8'hF8, 8'h82, 8'h92, 8'h99,   // 7 6 5 4
        8'hB0, 8'hA4, 8'hF9, 8'hC0    // 3 2 1 0
    };

    function automatic logic [7:0] seg_encode(input logic [3:0] nib);
        return SEG_TABLE[nib];
    endfunction

endpackage

// File: rtl/hex_seg_decoder.sv
// One hex digit: 4-bit nibble to active-low 7-segment pattern (dp off).
module hex_seg_decoder
    import slc3_io_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [7:0] o_seg
);

    assign o_seg = seg_encode(i_nibble);

endmodule

// File: rtl/slc3_io_responder.sv
// SLC-3 memory-mapped I/O target. Answers CPU bus cycles at IO_ADDR:
// reads return the synchronised switches, writes latch the 4-digit hex display.
// Each completed access produces a single-cycle R pulse so the CPU can leave
// its memory wait states.
//
// Build option: define SLC3_IO_LED_REG_EN to decode IO_ADDR-1 as an LED
// register target (same handshake); otherwise that address is ignored and
// LED is tied low.
//
// state | meaning
// IDLE  | no access in flight, waiting for a hit
// WAIT  | access latched, counting down wait cycles
// DONE  | access completes on this cycle's edge (R pulse, commit)
// HOLD  | waiting for the strobe/address to go away before re-arming
module slc3_io_responder
    import slc3_io_pkg::*;
#(
    parameter logic [15:0] IO_ADDR     = IO_HEX_ADDR,
    parameter int          WAIT_CYCLES = 2,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] ADDR,
    input  logic [15:0] Data_to_IO,
    input  logic        MEM_OE,
    input  logic        MEM_WE,
    output logic [15:0] Data_from_IO,
    output logic        R,
    input  logic [9:0]  SW,
    output logic [9:0]  LED,
    output logic [7:0]  HEX0,
    output logic [7:0]  HEX1,
    output logic [7:0]  HEX2,
    output logic [7:0]  HEX3
);

    localparam int CNT_W = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    io_state_t          r_state;
    io_state_t          w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_next;
    logic               w_latch;
    logic               w_commit;

    logic               r_op_wr;
    logic [15:0]        r_addr;
    logic [15:0]        r_data;

    logic [15:0]        r_hex;
    logic [15:0]        r_rd_data;
    logic               r_r;

    logic [SYNC_STAGES-1:0][9:0] r_sw_sync;
    logic [9:0]         w_sw_sync;

    logic               w_strobe;
    logic               w_hex_sel;
    logic               w_led_sel;
    logic               w_hit;
    logic               w_tgt_hex;
    logic [9:0]         w_led_rd;

    // Both strobes low counts as a write, so only MEM_WE decides the op.
    assign w_strobe  = ~MEM_OE | ~MEM_WE;
    assign w_hex_sel = (ADDR == IO_ADDR);
    assign w_hit     = (w_hex_sel | w_led_sel) & w_strobe;
    assign w_tgt_hex = (r_addr == IO_ADDR);
    assign w_sw_sync = r_sw_sync[SYNC_STAGES-1];

`ifdef SLC3_IO_LED_REG_EN
    localparam logic [15:0] LED_ADDR = IO_ADDR - 16'd1;
    logic [9:0] r_led;

    assign w_led_sel = (ADDR == LED_ADDR);
    assign w_led_rd  = r_led;
    assign LED       = r_led;

    // LED register: updated only by a completed write to the LED address
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_led <= 10'h000;
        end else if (w_commit && r_op_wr && !w_tgt_hex) begin
            r_led <= r_data[9:0];
        end
    end
`else
    assign w_led_sel = 1'b0;
    assign w_led_rd  = 10'h000;
    assign LED       = 10'h000;
`endif

    // FSM state and wait counter registers
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state logic; counter is tested for zero before it would decrement
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_latch      = 1'b0;
        w_commit     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_hit) begin
                    w_state_next = WAIT;
                    w_cnt_next   = CNT_LOAD;
                    w_latch      = 1'b1;
                end
            end
            WAIT: begin
                if (!w_hit) begin
                    w_state_next = IDLE;
                    w_cnt_next   = '0;
                end else if (r_cnt == '0) begin
                    w_state_next = DONE;
                end else begin
                    w_cnt_next = r_cnt - CNT_ONE;
                end
            end
            DONE: begin
                w_commit     = 1'b1;
                w_state_next = HOLD;
            end
            HOLD: begin
                if (!w_hit) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Capture the request on acceptance so later bus changes cannot alter it
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_op_wr <= 1'b0;
            r_addr  <= 16'h0000;
            r_data  <= 16'h0000;
        end else if (w_latch) begin
            r_op_wr <= ~MEM_WE;
            r_addr  <= ADDR;
            r_data  <= Data_to_IO;
        end
    end

    // Completion: R pulse, hex write commit and read data update share one edge
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_r       <= 1'b0;
            r_hex     <= 16'h0000;
            r_rd_data <= 16'h0000;
        end else begin
            r_r <= w_commit;
            if (w_commit && r_op_wr && w_tgt_hex) begin
                r_hex <= r_data;
            end
            if (w_commit && !r_op_wr) begin
                r_rd_data <= w_tgt_hex ? {6'b0, w_sw_sync} : {6'b0, w_led_rd};
            end
        end
    end

    // Switch synchroniser; the last stage is the only one ever sampled
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_sw_sync <= '0;
        end else begin
            r_sw_sync <= {r_sw_sync[SYNC_STAGES-2:0], SW};
        end
    end

    assign R            = r_r;
    assign Data_from_IO = r_rd_data;

    hex_seg_decoder u_hex0 (.i_nibble(r_hex[3:0]),   .o_seg(HEX0));
    hex_seg_decoder u_hex1 (.i_nibble(r_hex[7:4]),   .o_seg(HEX1));
    hex_seg_decoder u_hex2 (.i_nibble(r_hex[11:8]),  .o_seg(HEX2));
    hex_seg_decoder u_hex3 (.i_nibble(r_hex[15:12]), .o_seg(HEX3));

endmodule

// File: tb/tb_slc3_io_responder.sv
// Scoreboard bench for slc3_io_responder. Stimulus pushes the expected
// completion (cycle, read data, display, LED) into a queue; a monitor pops and
// compares on every R pulse. Honours SLC3_IO_LED_REG_EN like the design.
module tb_slc3_io_responder;

    localparam int WAIT_CYCLES = 2;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [15:0] ADDR;
    logic [15:0] Data_to_IO;
    logic        MEM_OE;
    logic        MEM_WE;
    logic [15:0] Data_from_IO;
    logic        R;
    logic [9:0]  SW;
    logic [9:0]  LED;
    logic [7:0]  HEX0, HEX1, HEX2, HEX3;

    slc3_io_responder dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .ADDR         (ADDR),
        .Data_to_IO   (Data_to_IO),
        .MEM_OE       (MEM_OE),
        .MEM_WE       (MEM_WE),
        .Data_from_IO (Data_from_IO),
        .R            (R),
        .SW           (SW),
        .LED          (LED),
        .HEX0         (HEX0),
        .HEX1         (HEX1),
        .HEX2         (HEX2),
        .HEX3         (HEX3)
    );

    always #10 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc++;

    typedef struct {
        int          cyc;
        logic [15:0] rd;
        logic [15:0] hex;
        logic [9:0]  led;
    } exp_t;

    exp_t sb[$];

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] m_hex;
    logic [15:0] m_rd;
    logic [9:0]  m_led;
    logic [9:0]  m_sw;

`ifdef SLC3_IO_LED_REG_EN
    localparam bit LED_EN = 1'b1;
`else
    localparam bit LED_EN = 1'b0;
`endif

    function automatic logic [7:0] seg7(input logic [3:0] d);
        case (d)
            4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
            4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
            4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
            4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
        endcase
    endfunction

    function automatic logic [31:0] disp(input logic [15:0] v);
        return {seg7(v[15:12]), seg7(v[11:8]), seg7(v[7:4]), seg7(v[3:0])};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every R pulse must match the oldest outstanding expectation
    always @(negedge Clk) begin : monitor
        exp_t e;
        if (Reset === 1'b1 && R !== 1'b0) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL spurious_r: R=%b at cycle %0d, required no response", R, cyc);
            end else begin
                e = sb.pop_front();
                check("r_cycle", cyc, e.cyc);
                check("rd_data", {16'h0, Data_from_IO}, {16'h0, e.rd});
                check("hex_out", {HEX3, HEX2, HEX1, HEX0}, disp(e.hex));
                check("led_out", {22'h0, LED}, {22'h0, e.led});
            end
        end
    end

    task automatic idle_bus();
        MEM_OE = 1'b1;
        MEM_WE = 1'b1;
        ADDR   = 16'h0000;
    endtask

    task automatic set_sw(input logic [9:0] v);
        @(negedge Clk);
        SW   = v;
        m_sw = v;
        repeat (3) @(negedge Clk);
    endtask

    // One bus access; abort releases the strobe during the wait phase
    task automatic access(input logic [15:0] a, input bit wr, input bit both,
                          input logic [15:0] d, input int hold, input bit abort);
        bit   resp;
        exp_t e;
        resp = (a == 16'hFFFF) || (LED_EN && a == 16'hFFFE);
        @(negedge Clk);
        ADDR       = a;
        Data_to_IO = d;
        MEM_WE     = wr ? 1'b0 : 1'b1;
        MEM_OE     = (!wr || both) ? 1'b0 : 1'b1;
        if (abort) begin
            @(negedge Clk);
            MEM_OE = 1'b1;
            MEM_WE = 1'b1;
            repeat (4) @(negedge Clk);
            check("abort_hex", {HEX3, HEX2, HEX1, HEX0}, disp(m_hex));
            check("abort_led", {22'h0, LED}, {22'h0, m_led});
            return;
        end
        if (resp) begin
            if (wr) begin
                if (a == 16'hFFFF) m_hex = d;
                else               m_led = d[9:0];
            end else begin
                m_rd = (a == 16'hFFFF) ? {6'b0, m_sw} : {6'b0, m_led};
            end
            e.cyc = cyc + 1 + WAIT_CYCLES + 1;
            e.rd  = m_rd;
            e.hex = m_hex;
            e.led = m_led;
            sb.push_back(e);
        end
        repeat (hold) @(negedge Clk);
        idle_bus();
        repeat (2) @(negedge Clk);
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        idle_bus();
        repeat (3) @(negedge Clk);
        Reset = 1'b1;
        m_hex = 16'h0000;
        m_rd  = 16'h0000;
        m_led = 10'h000;
        repeat (2) @(negedge Clk);
    endtask

    initial begin
        logic [15:0] a;
        int          pick;
        Reset      = 1'b0;
        Data_to_IO = 16'h0000;
        SW         = 10'h000;
        m_sw       = 10'h000;
        idle_bus();
        do_reset();

        check("reset_hex", {HEX3, HEX2, HEX1, HEX0}, 32'hC0C0C0C0);
        check("reset_r", {31'h0, R}, 32'h0);
        check("reset_rd", {16'h0, Data_from_IO}, 32'h0);
        check("reset_led", {22'h0, LED}, 32'h0);

        // Write 1A3F with the strobe held well past the R pulse
        access(16'hFFFF, 1'b1, 1'b0, 16'h1A3F, 8, 1'b0);
        check("hex_1a3f", {HEX3, HEX2, HEX1, HEX0}, 32'hF988B08E);

        // Switch read, data must stay after strobe release
        set_sw(10'h2B3);
        access(16'hFFFF, 1'b0, 1'b0, 16'h0000, 5, 1'b0);
        repeat (3) @(negedge Clk);
        check("rd_held", {16'h0, Data_from_IO}, 32'h0000_02B3);

        // Aborted write leaves the display alone; the next one completes
        access(16'hFFFF, 1'b1, 1'b0, 16'h0000, 5, 1'b1);
        check("abort_keeps_1a3f", {HEX3, HEX2, HEX1, HEX0}, 32'hF988B08E);
        access(16'hFFFF, 1'b1, 1'b0, 16'h5C07, 5, 1'b0);

        // Both strobes low is a write and must not touch the read data
        access(16'hFFFF, 1'b1, 1'b1, 16'h9E2D, 5, 1'b0);
        check("both_keeps_rd", {16'h0, Data_from_IO}, 32'h0000_02B3);

        // Reset during the wait phase of a write
        @(negedge Clk);
        ADDR       = 16'hFFFF;
        Data_to_IO = 16'hBEEF;
        MEM_WE     = 1'b0;
        @(negedge Clk);
        Reset = 1'b0;
        idle_bus();
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        m_hex = 16'h0000;
        m_rd  = 16'h0000;
        m_led = 10'h000;
        repeat (6) @(negedge Clk);
        check("reset_abort_hex", {HEX3, HEX2, HEX1, HEX0}, 32'hC0C0C0C0);
        check("reset_abort_rd", {16'h0, Data_from_IO}, 32'h0);

        // LED address
        access(16'hFFFE, 1'b1, 1'b0, 16'h03FF, 5, 1'b0);
        access(16'hFFFE, 1'b0, 1'b0, 16'h0000, 5, 1'b0);
        check("led_addr_led", {22'h0, LED}, LED_EN ? 32'h3FF : 32'h0);
        check("led_addr_rd", {16'h0, Data_from_IO}, LED_EN ? 32'h03FF : 32'h0);

        // Randomised traffic
        for (int i = 0; i < 70; i++) begin
            if ($urandom_range(0, 5) == 0) set_sw(10'($urandom));
            pick = $urandom_range(0, 7);
            if (pick < 4)      a = 16'hFFFF;
            else if (pick < 6) a = 16'hFFFE;
            else               a = 16'($urandom_range(0, 16'hFFFD));
            access(a, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                   16'($urandom), $urandom_range(4, 8), ($urandom_range(0, 6) == 0));
        end

        repeat (10) @(negedge Clk);
        check("pending_responses", sb.size(), 0);
        check("final_hex", {HEX3, HEX2, HEX1, HEX0}, disp(m_hex));
        check("final_led", {22'h0, LED}, {22'h0, m_led});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
